data_mem_ram: RTL and testbench



---
 rtl/data_mem_ram.sv | 60 ++++++
 tb/tb_data_mem_ram.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ram.sv
// rtl/data_mem_ram.sv - simple dual-port RAM with active-low enables and registered read (DATA_MEM_WR_BYPASS_EN selects write-first)
module data_mem_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    always_comb begin
        mem_d      = mem_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (!wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
        // Read samples the pre-write array, so a same-address collision returns old data.
        if (!rd_en) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem_q[rd_addr];
`ifdef DATA_MEM_WR_BYPASS_EN
            if (!wr_en && (wr_addr == rd_addr)) begin
                rd_data_d = wr_data;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_data_mem_ram.sv
// tb/tb_data_mem_ram.sv - directed self-checking bench for data_mem_ram
module tb_data_mem_ram;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic       rd_en;
    logic [2:0] wr_addr;
    logic [2:0] rd_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       rd_valid;

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b1;
        rd_en = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b1;
        wr_addr = 3'd0; rd_addr = 3'd0; wr_data = 8'h01;
        #2;
        cyc();
        cyc();
        n_cmp++;
        if (rd_data !== 8'h00) begin
            n_bad++; $display("FAIL reset_rd_data: got %h expected %h", rd_data, 8'h00);
        end
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_rd_valid: got %b expected %b", rd_valid, 1'b0);
        end
        reset = 1'b1; wr_en = 1'b1; rd_en = 1'b0; rd_addr = 3'd0;
        cyc();
        n_cmp++;
        if (rd_data !== 8'h00) begin
            n_bad++; $display("FAIL reset_blocked_write: got %h expected %h", rd_data, 8'h00);
        end
        n_cmp++;
        if (rd_valid !== 1'b1) begin
            n_bad++; $display("FAIL reset_first_read_valid: got %b expected %b", rd_valid, 1'b1);
        end
        idle();
        cyc();
    endtask

    task automatic test_seq_write();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h02; exp_d[1] = 8'h03; exp_d[2] = 8'h04;
        for (int k = 0; k < 3; k++) begin
            wr_en = 1'b0; wr_addr = 3'(k + 1); wr_data = exp_d[k];
            cyc();
        end
        wr_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rd_en = 1'b0; rd_addr = 3'(k + 1);
            cyc();
            n_cmp++;
            if (rd_data !== exp_d[k] || rd_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL seq_read_%0d: got %h/%b expected %h/1", k + 1, rd_data, rd_valid, exp_d[k]);
            end
        end
        idle();
    endtask

    task automatic test_read_disable();
        rd_en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            rd_addr = 3'(k);
            cyc();
            n_cmp++;
            if (rd_data !== 8'h04 || rd_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL read_disable_%0d: got %h/%b expected 04/0", k, rd_data, rd_valid);
            end
        end
    endtask

    task automatic test_collision();
        wr_en = 1'b0; wr_addr = 3'd5; wr_data = 8'hAA;
        cyc();
        wr_data = 8'h55; rd_en = 1'b0; rd_addr = 3'd5;
        cyc();
        n_cmp++;
`ifdef DATA_MEM_WR_BYPASS_EN
        if (rd_data !== 8'h55) begin
            n_bad++; $display("FAIL collision_bypass: got %h expected %h", rd_data, 8'h55);
        end
`else
        if (rd_data !== 8'hAA) begin
            n_bad++; $display("FAIL collision_old_data: got %h expected %h", rd_data, 8'hAA);
        end
`endif
        wr_en = 1'b1;
        cyc();
        n_cmp++;
        if (rd_data !== 8'h55 || rd_valid !== 1'b1) begin
            n_bad++; $display("FAIL collision_followup: got %h/%b expected 55/1", rd_data, rd_valid);
        end
        idle();
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 8; k++) begin
            wr_en = 1'b0; wr_addr = 3'(k); wr_data = 8'hFF;
            cyc();
        end
        wr_en = 1'b1; rd_en = 1'b0; rd_addr = 3'd6;
        cyc();
        n_cmp++;
        if (rd_data !== 8'hFF) begin
            n_bad++; $display("FAIL pre_reset_read: got %h expected %h", rd_data, 8'hFF);
        end
        // In-flight write at the next edge must be lost.
        wr_en = 1'b0; wr_addr = 3'd2; wr_data = 8'h77;
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (rd_data !== 8'h00 || rd_valid !== 1'b0) begin
            n_bad++; $display("FAIL async_reset_clear: got %h/%b expected 00/0", rd_data, rd_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        wr_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rd_en = 1'b0; rd_addr = 3'(k);
            cyc();
            n_cmp++;
            if (rd_data !== 8'h00 || rd_valid !== 1'b1) begin
                n_bad++; $display("FAIL post_reset_read_%0d: got %h/%b expected 00/1", k, rd_data, rd_valid);
            end
        end
        idle();
    endtask

    task automatic test_full_depth();
        for (int k = 0; k < 8; k++) begin
            wr_en = 1'b0; wr_addr = 3'(k); wr_data = 8'(k + 8'h10);
            cyc();
        end
        wr_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rd_en = 1'b0; rd_addr = 3'(k);
            cyc();
            n_cmp++;
            if (rd_data !== 8'(k + 8'h10)) begin
                n_bad++; $display("FAIL full_depth_%0d: got %h expected %h", k, rd_data, 8'(k + 8'h10));
            end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        // Independent ports: read addr 0 while overwriting addr 1, then read addr 1.
        wr_en = 1'b0; wr_addr = 3'd1; wr_data = 8'hC3;
        rd_en = 1'b0; rd_addr = 3'd0;
        cyc();
        n_cmp++;
        if (rd_data !== 8'h10 || rd_valid !== 1'b1) begin
            n_bad++; $display("FAIL b2b_read0: got %h/%b expected 10/1", rd_data, rd_valid);
        end
        wr_en = 1'b1; rd_addr = 3'd1;
        cyc();
        n_cmp++;
        if (rd_data !== 8'hC3) begin
            n_bad++; $display("FAIL b2b_read1: got %h expected %h", rd_data, 8'hC3);
        end
        rd_addr = 3'd7;
        cyc();
        n_cmp++;
        if (rd_data !== 8'h17) begin
            n_bad++; $display("FAIL b2b_read7: got %h expected %h", rd_data, 8'h17);
        end
        idle();
        cyc();
        n_cmp++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h17) begin
            n_bad++; $display("FAIL b2b_idle: got %h/%b expected 17/0", rd_data, rd_valid);
        end
    endtask

    initial begin
        test_reset();
        test_seq_write();
        test_read_disable();
        test_collision();
        test_async_reset();
        test_full_depth();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
